inst_encoder: RTL and testbench

Instruction encoder and program loader for the MIPS 5-stage pipelined CPU: the encoding counterpart of the controller's instruction decode. It accepts symbolic instruction commands (mnemonic code plus register, immediate and target fields) over a valid/ready stream. It assembles each command into a 32-bit MIPS word and writes the words to consecutive instruction-memory addresses through a stallable write port. It sits between the debug/host loader path and instruction memory, and is used to load programs while the CPU is held in reset.

---
 rtl/inst_encoder.sv | 146 ++++++++++++++
 tb/tb_inst_encoder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// Assembles symbolic MIPS commands into 32-bit words and streams them to
// consecutive instruction-memory addresses through a stallable write port.
module inst_encoder #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_op,
    input  logic [4:0]            cmd_rs,
    input  logic [4:0]            cmd_rt,
    input  logic [4:0]            cmd_rd,
    input  logic [15:0]           cmd_imm,
    input  logic [25:0]           cmd_target,
    output logic                  imem_wen,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_data,
    input  logic                  imem_ready,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   written
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   acc_q, acc_d;
    logic [ADDR_WIDTH:0]   wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  out_vld_q, out_vld_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [31:0]           out_data_q, out_data_d;
    logic                  wr_hs;
    logic                  accept;

    function automatic logic [31:0] encode(
        input logic [3:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] w;
        w = 32'h0000_0000;
        case (op)
            4'd1:    w = {6'h00, rs, rt, rd, 5'h00, 6'h20};
            4'd2:    w = {6'h00, rs, rt, rd, 5'h00, 6'h22};
            4'd3:    w = {6'h00, rs, rt, rd, 5'h00, 6'h24};
            4'd4:    w = {6'h00, rs, rt, rd, 5'h00, 6'h25};
            4'd5:    w = {6'h00, rs, rt, rd, 5'h00, 6'h2A};
            4'd6:    w = {6'h00, rs, 15'h0000, 6'h08};
            4'd7:    w = {6'h02, target};
            4'd8:    w = {6'h03, target};
            4'd9:    w = {6'h04, rs, rt, imm};
            4'd10:   w = {6'h05, rs, rt, imm};
            4'd11:   w = {6'h08, rs, rt, imm};
            4'd12:   w = {6'h0C, rs, rt, imm};
            4'd13:   w = {6'h0D, rs, rt, imm};
            4'd14:   w = {6'h23, rs, rt, imm};
            4'd15:   w = {6'h2B, rs, rt, imm};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        acc_d      = acc_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        out_vld_d  = out_vld_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;

        wr_hs     = out_vld_q && imem_ready;
        cmd_ready = (state_q == S_RUN) && (acc_q < len_q) && (!out_vld_q || imem_ready);
        accept    = cmd_valid && cmd_ready;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    len_d  = length;
                    acc_d  = '0;
                    wr_d   = '0;
                    addr_d = base_addr;
                    state_d = (length != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (wr_hs) begin
                    wr_d      = wr_q + 1'b1;
                    out_vld_d = 1'b0;
                    if (wr_d == len_q) begin
                        state_d = S_DONE;
                    end
                end
                // A write handshake and a new accept on the same edge reload without a bubble.
                if (accept) begin
                    out_vld_d  = 1'b1;
                    out_addr_d = addr_q;
                    out_data_d = encode(cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target);
                    addr_d     = addr_q + 1'b1;
                    acc_d      = acc_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            acc_q      <= '0;
            wr_q       <= '0;
            addr_q     <= '0;
            out_vld_q  <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            acc_q      <= acc_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            out_vld_q  <= out_vld_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
        end
    end

    assign imem_wen  = out_vld_q;
    assign imem_addr = out_addr_q;
    assign imem_data = out_data_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign written   = wr_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: opcode table, directed load runs and randomized runs
// checked against an arithmetic model of the MIPS encodings.
module tb_inst_encoder;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] target;
    } cmd_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] exp;
    } vec_t;

    localparam int unsigned FUNCT [0:15] = '{0, 32, 34, 36, 37, 42, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    localparam int unsigned OPC   [0:15] = '{0, 0, 0, 0, 0, 0, 0, 2, 3, 4, 5, 8, 12, 13, 35, 43};

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  length;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
    logic [15:0] cmd_imm;
    logic [25:0] cmd_target;
    logic        imem_wen;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        imem_ready;
    logic        busy;
    logic        done;
    logic [8:0]  written;

    int   errors = 0;
    int   checks = 0;
    int   cyc_cnt = 0;
    int   acc_cyc0;
    int   done_cyc;
    cmd_t cmds [64];
    wr_t  obs_q [$];
    vec_t tbl [16];

    inst_encoder #(.ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
        .cmd_target(cmd_target), .imem_wen(imem_wen), .imem_addr(imem_addr),
        .imem_data(imem_data), .imem_ready(imem_ready), .busy(busy), .done(done),
        .written(written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (!rst && imem_wen && imem_ready) begin
            obs_q.push_back('{addr: imem_addr, data: imem_data, cyc: cyc_cnt});
        end
    end

    function automatic logic [31:0] ref_word(input cmd_t c);
        longint w;
        int     k;
        k = int'(c.op);
        if (k == 0)
            w = 0;
        else if (k <= 5)
            w = longint'(c.rs) * (1 << 21) + longint'(c.rt) * (1 << 16)
              + longint'(c.rd) * (1 << 11) + longint'(FUNCT[k]);
        else if (k == 6)
            w = longint'(c.rs) * (1 << 21) + 8;
        else if (k <= 8)
            w = longint'(OPC[k]) * (1 << 26) + longint'(c.target);
        else
            w = longint'(OPC[k]) * (1 << 26) + longint'(c.rs) * (1 << 21)
              + longint'(c.rt) * (1 << 16) + longint'(c.imm);
        return w[31:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_cmd(input cmd_t c);
        cmd_op = c.op; cmd_rs = c.rs; cmd_rt = c.rt; cmd_rd = c.rd;
        cmd_imm = c.imm; cmd_target = c.target;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cmds(input int n);
        for (int i = 0; i < n; i++) begin
            cmds[i].op     = 4'($urandom);
            cmds[i].rs     = 5'($urandom);
            cmds[i].rt     = 5'($urandom);
            cmds[i].rd     = 5'($urandom);
            cmds[i].imm    = 16'($urandom);
            cmds[i].target = 26'($urandom);
        end
    endtask

    // Runs one load of cmds[0..len-1]; stall holds imem_ready low 4 cycles on the
    // second write, rnd randomizes valid/ready, inj pulses start mid-run.
    task automatic run_stream(input logic [7:0] base, input int len,
                              input bit stall, input bit rnd, input bit inj);
        int idx;
        int loops;
        int stall_left;
        obs_q.delete();
        idx = 0;
        loops = 0;
        stall_left = stall ? 4 : 0;
        acc_cyc0 = -1;
        done_cyc = -1;
        start = 1'b1; base_addr = base; length = 9'(len);
        tick();
        start = 1'b0;
        while (!done && loops < 400) begin
            cmd_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            set_cmd(cmds[(idx < len) ? idx : len - 1]);
            imem_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (stall && imem_wen && obs_q.size() == 1 && stall_left > 0) begin
                imem_ready = 1'b0;
                stall_left--;
            end
            if (inj && loops == 1) begin
                start = 1'b1; base_addr = 8'h40; length = 9'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (stall && imem_wen && !imem_ready) begin
                chk("stall_addr", 64'(imem_addr), 64'(8'(base + 8'd1)));
                chk("stall_data", 64'(imem_data), 64'(ref_word(cmds[1])));
                chk("stall_cmd_ready", 64'(cmd_ready), 64'd0);
            end
            if (idx >= len) chk("ready_after_len", 64'(cmd_ready), 64'd0);
            if (cmd_valid && cmd_ready && idx < len) begin
                if (acc_cyc0 < 0) acc_cyc0 = cyc_cnt;
                idx++;
            end
            tick();
            loops++;
        end
        start = 1'b0;
        cmd_valid = 1'b0;
        imem_ready = 1'b1;
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL run_timeout: actual=done 0 required=done 1");
        end
        done_cyc = cyc_cnt;
        if (stall) chk("stall_cycles_used", 64'(stall_left), 64'd0);
        chk("written_at_done", 64'(written), 64'(len));
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("write_count", 64'(obs_q.size()), 64'(len));
        for (int i = 0; i < obs_q.size() && i < len; i++) begin
            chk($sformatf("addr[%0d]", i), 64'(obs_q[i].addr), 64'(8'(base + 8'(i))));
            chk($sformatf("data[%0d]", i), 64'(obs_q[i].data), 64'(ref_word(cmds[i])));
        end
    endtask

    initial begin
        tbl[0]  = '{4'd0,  32'h0000_0000};
        tbl[1]  = '{4'd1,  32'h00A6_3820};
        tbl[2]  = '{4'd2,  32'h00A6_3822};
        tbl[3]  = '{4'd3,  32'h00A6_3824};
        tbl[4]  = '{4'd4,  32'h00A6_3825};
        tbl[5]  = '{4'd5,  32'h00A6_382A};
        tbl[6]  = '{4'd6,  32'h00A0_0008};
        tbl[7]  = '{4'd7,  32'h0BFF_FFFF};
        tbl[8]  = '{4'd8,  32'h0FFF_FFFF};
        tbl[9]  = '{4'd9,  32'h10A6_0004};
        tbl[10] = '{4'd10, 32'h14A6_0004};
        tbl[11] = '{4'd11, 32'h20A6_0004};
        tbl[12] = '{4'd12, 32'h30A6_0004};
        tbl[13] = '{4'd13, 32'h34A6_0004};
        tbl[14] = '{4'd14, 32'h8CA6_0004};
        tbl[15] = '{4'd15, 32'hACA6_0004};

        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0;
        cmd_imm = '0; cmd_target = '0; imem_ready = 1'b1;
        repeat (3) tick();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_imem_wen", 64'(imem_wen), 64'd0);
        chk("rst_imem_addr", 64'(imem_addr), 64'd0);
        chk("rst_imem_data", 64'(imem_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_written", 64'(written), 64'd0);
        rst = 1'b0;
        tick();

        // Basic three-instruction program.
        cmds[0] = '{4'd1,  5'd1, 5'd2, 5'd3, 16'h0000, 26'h0};
        cmds[1] = '{4'd11, 5'd1, 5'd4, 5'd0, 16'hFFFF, 26'h0};
        cmds[2] = '{4'd7,  5'd0, 5'd0, 5'd0, 16'h0000, 26'h0000040};
        run_stream(8'h10, 3, 1'b0, 1'b0, 1'b0);
        if (obs_q.size() == 3) begin
            chk("t1_word0", 64'(obs_q[0].data), 64'h0022_1820);
            chk("t1_word1", 64'(obs_q[1].data), 64'h2024_FFFF);
            chk("t1_word2", 64'(obs_q[2].data), 64'h0800_0040);
            chk("t1_latency", 64'(obs_q[0].cyc), 64'(acc_cyc0 + 1));
            chk("t1_back_to_back_1", 64'(obs_q[1].cyc), 64'(obs_q[0].cyc + 1));
            chk("t1_back_to_back_2", 64'(obs_q[2].cyc), 64'(obs_q[1].cyc + 1));
            chk("t1_done_timing", 64'(done_cyc), 64'(obs_q[2].cyc + 1));
        end

        // Every opcode against the constant table.
        for (int i = 0; i < 16; i++) cmds[i] = '{tbl[i].op, 5'd5, 5'd6, 5'd7, 16'h0004, 26'h3FFFFFF};
        run_stream(8'h80, 16, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i < obs_q.size()) chk($sformatf("tbl_op%0d", i), 64'(obs_q[i].data), 64'(tbl[i].exp));
        end

        // Stall on the second write.
        rand_cmds(3);
        run_stream(8'h30, 3, 1'b1, 1'b0, 1'b0);

        // Address wrap.
        rand_cmds(2);
        run_stream(8'hFF, 2, 1'b0, 1'b0, 1'b0);
        if (obs_q.size() == 2) begin
            chk("wrap_addr0", 64'(obs_q[0].addr), 64'hFF);
            chk("wrap_addr1", 64'(obs_q[1].addr), 64'h00);
        end

        // Zero-length run.
        obs_q.delete();
        start = 1'b1; base_addr = 8'h55; length = 9'd0;
        tick();
        start = 1'b0;
        chk("len0_done", 64'(done), 64'd1);
        chk("len0_written", 64'(written), 64'd0);
        chk("len0_busy", 64'(busy), 64'd0);
        chk("len0_wen", 64'(imem_wen), 64'd0);
        repeat (3) tick();
        chk("len0_no_writes", 64'(obs_q.size()), 64'd0);
        chk("len0_done_holds", 64'(done), 64'd1);

        // Start pulse during RUN is ignored.
        rand_cmds(3);
        run_stream(8'h20, 3, 1'b0, 1'b0, 1'b1);

        // Reset while a write is stalled.
        rand_cmds(3);
        obs_q.delete();
        start = 1'b1; base_addr = 8'h60; length = 9'd3;
        tick();
        start = 1'b0;
        cmd_valid = 1'b1;
        set_cmd(cmds[0]);
        imem_ready = 1'b1;
        for (int k = 0; k < 20 && !(obs_q.size() == 1 && imem_wen); k++) begin
            if (cmd_ready) set_cmd(cmds[1]);
            tick();
        end
        cmd_valid = 1'b0;
        imem_ready = 1'b0;
        tick();
        chk("prerst_wen", 64'(imem_wen), 64'd1);
        chk("prerst_written", 64'(written), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_wen", 64'(imem_wen), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_written", 64'(written), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
        imem_ready = 1'b1;
        tick();

        // Randomized runs with random valid/ready.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 20);
            rand_cmds(n);
            run_stream(8'($urandom), n, 1'b0, 1'b1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
